// File: rtl/jtcop_paldma_if.sv
// Palette DMA bus: CPU palette buffer read port plus video palette RAM write port.
// The DMA engine is the master; the two RAMs sit on the slave side.
interface jtcop_paldma_if #(
  parameter int unsigned AW = 10
);
  logic [AW-1:0] src_addr;
  logic [15:0]   src_dout;
  logic [AW-1:0] pal_addr;
  logic [15:0]   pal_dout;
  logic [1:0]    pal_we;

  modport master (
    output src_addr,
    input  src_dout,
    output pal_addr,
    output pal_dout,
    output pal_we
  );

  modport slave (
    input  src_addr,
    output src_dout,
    input  pal_addr,
    input  pal_dout,
    input  pal_we
  );
endinterface

// File: rtl/jtcop_paldma.sv
// Palette DMA writer: copies the CPU palette buffer into the video palette RAM,
// one word per clock, only while vertical blanking is active (LVBL low).
module jtcop_paldma #(
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LVBL,
  input  logic              dma_req,
  jtcop_paldma_if.master    bus,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VB = 2'd1;
  localparam logic [1:0] COPY    = 2'd2;

  logic [1:0]    state;
  logic [AW:0]   rd_cnt;
  logic          pending;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   dout_q;

  logic          issue;
  logic          finish;
  logic          restart;

  // rd_cnt[AW] marks that every word has been issued; no second pass.
  assign issue   = (state == COPY) && !LVBL && !rd_cnt[AW];
  assign finish  = (state == COPY) && rd_cnt[AW];
  assign restart = pending || dma_req;

  // Source data arrives one clock after the address, i.e. in the write
  // cycle itself, so the write data is passed through and held afterwards.
  assign bus.src_addr = rd_cnt[AW-1:0];
  assign bus.pal_addr = addr_q;
  assign bus.pal_dout = we_q ? bus.src_dout : dout_q;
  assign bus.pal_we   = {2{we_q}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      done <= 1'b0;
      we_q <= issue;

      if (issue) begin
        addr_q <= rd_cnt[AW-1:0];
        rd_cnt <= rd_cnt + 1'b1;
      end

      if (we_q) begin
        dout_q <= bus.src_dout;
      end

      if (busy && dma_req) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (dma_req) begin
            state  <= WAIT_VB;
            rd_cnt <= '0;
            busy   <= 1'b1;
          end
        end

        WAIT_VB: begin
          if (!LVBL) begin
            state <= COPY;
          end
        end

        COPY: begin
          if (finish) begin
            done    <= 1'b1;
            pending <= 1'b0;
            // A request collected during (or coinciding with) the last
            // write chains straight into the next transfer.
            if (restart) begin
              state  <= WAIT_VB;
              rd_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (LVBL && !we_q) begin
            state <= WAIT_VB;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
